// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state type and status-flag struct for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1111;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_GT  = 4'b0011;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_DIV = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: shift-add multiplier, plus a restoring divider when SEQ_ALU_DIV_EN is defined.
// One step per cycle for WIDTH cycles after start; res carries the value produced by the current step.
module seq_alu_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] res
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] step_res;

`ifdef SEQ_ALU_DIV_EN
  logic               mode_q, mode_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic [2*WIDTH-1:0] div_step;

  // acc holds {remainder, dividend/quotient}; quotient bits shift in from the right
  always_comb begin
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (!rem_diff[WIDTH]) begin
      div_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign step_res    = mode_q ? div_step : mul_step;
  assign div_by_zero = mode_q && (opb_q == '0);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign step_res    = mul_step;
  assign div_by_zero = 1'b0;
`endif

  assign mul_step = opb_q[0] ? (acc_q + opa_q) : acc_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign res      = step_res;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
`ifdef SEQ_ALU_DIV_EN
    mode_d = mode_q;
`endif
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      opa_d  = {{WIDTH{1'b0}}, a};
      opb_d  = b;
`ifdef SEQ_ALU_DIV_EN
      mode_d = mode;
      acc_d  = mode ? {{WIDTH{1'b0}}, a} : '0;
`else
      acc_d  = '0;
`endif
    end else if (busy_q) begin
      acc_d = step_res;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
      end
`ifdef SEQ_ALU_DIV_EN
      if (!mode_q) begin
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
      end
`else
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
`ifdef SEQ_ALU_DIV_EN
      mode_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
`ifdef SEQ_ALU_DIV_EN
      mode_q <= mode_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, iterative MUL and status flags.
// Optional DIV (opcode 0111) is enabled by defining SEQ_ALU_DIV_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready = IDLE | (HOLD & out_ready), out_valid = HOLD, results held stable until taken.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_v,
  output state_e             dbg_state
);

  localparam int SHW = $clog2(WIDTH);
  localparam int RW  = 2 * WIDTH;

  state_e          state_q, state_d;
  logic [RW-1:0]   result_q, result_d;
  flags_t          flags_q, flags_d;

  logic            accept;
  logic            is_iter;
  logic            iter_start;
  logic            iter_mode;
  logic            iter_done;
  logic            iter_dz;
  logic [RW-1:0]   iter_res;

  logic [WIDTH:0]  sum;
  logic [WIDTH:0]  diff;
  logic [SHW-1:0]  shamt;
  logic [RW-1:0]   alu_res;
  flags_t          alu_flags;

`ifdef SEQ_ALU_DIV_EN
  assign is_iter   = (sel == OP_MUL) || (sel == OP_DIV);
  assign iter_mode = (sel == OP_DIV);
`else
  assign is_iter   = (sel == OP_MUL);
  assign iter_mode = 1'b0;
`endif

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (iter_start),
    .mode        (iter_mode),
    .a           (a),
    .b           (b),
    .done        (iter_done),
    .div_by_zero (iter_dz),
    .res         (iter_res)
  );

  // single-cycle ops; MUL/DIV fall to the default here and are never selected from it
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    shamt     = b[SHW-1:0];
    alu_res   = '0;
    alu_flags = '0;
    case (sel)
      OP_ADD: begin
        alu_res     = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        alu_flags.c = sum[WIDTH];
        alu_flags.v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res     = {{WIDTH{1'b0}}, diff[WIDTH-1:0]};
        alu_flags.c = diff[WIDTH];
        alu_flags.v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a ^ b};
      OP_EQ:   alu_res = {RW{a == b}};
      OP_GT:   alu_res = {RW{a > b}};
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, a} << shamt;
      OP_SHR:  alu_res = {{WIDTH{1'b0}}, a >> shamt};
      default: alu_res = '0;
    endcase
    alu_flags.z = (alu_res == '0);
  end

  // state register and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = is_iter ? BUSY : HOLD;
      end
      BUSY: begin
        if (iter_done) state_d = HOLD;
      end
      HOLD: begin
        if (accept)         state_d = is_iter ? BUSY : HOLD;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    out_valid  = (state_q == HOLD);
    accept     = in_valid && in_ready;
    iter_start = accept && is_iter;
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    if (accept && !is_iter) begin
      result_d = alu_res;
      flags_d  = alu_flags;
    end else if ((state_q == BUSY) && iter_done) begin
      result_d  = iter_res;
      flags_d.z = (iter_res == '0);
      flags_d.c = 1'b0;
      flags_d.v = iter_dz;
    end
  end

  assign result    = result_q;
  assign flag_z    = flags_q.z;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8): driver pushes expected {result,z,c,v}, a negedge monitor pops on each transfer.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W  = 8;
  localparam int RW = 2 * W;
  localparam int EW = RW + 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    sel;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] result;
  logic          flag_z;
  logic          flag_c;
  logic          flag_v;
  state_e        dbg_state;

  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result %h, expected no output", result);
      end else begin
        chk("result_flags", {result, flag_z, flag_c, flag_v}, exp_q.pop_front());
      end
    end
  end

  // issue one op, then measure latency and cycles with in_ready low
  task automatic issue(input string name, input logic [3:0] op, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic [RW-1:0] er, input logic ez,
                       input logic ec, input logic ev, input int elat, input int ebusy);
    int n;
    int lat;
    int bz;
    sel      = op;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    exp_q.push_back({er, ez, ec, ev});
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: in_ready stayed 0, expected 1", name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    bz  = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (!in_ready) bz++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_cycles"}, bz, ebusy);
    @(posedge clk);
    #1;
  endtask

  // drive an op that must be accepted in the very next edge while HOLD drains
  task automatic b2b(input string name, input logic [3:0] op, input logic [W-1:0] xa,
                     input logic [W-1:0] xb, input logic [RW-1:0] er, input logic ez,
                     input logic ec, input logic ev);
    sel      = op;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    exp_q.push_back({er, ez, ec, ev});
    @(negedge clk);
    chk({name, "_ready"}, in_ready, 1'b1);
    chk({name, "_state"}, dbg_state, HOLD);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sel       = OP_ADD;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {flag_z, flag_c, flag_v}, 3'b000);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //    name     op      a      b      result    z     c     v    lat busy
    issue("add_c",  OP_ADD, 8'hF0, 8'h20, 16'h0010, 1'b0, 1'b1, 1'b0, 1, 0);
    issue("sub_b",  OP_SUB, 8'h03, 8'h05, 16'h00FE, 1'b0, 1'b1, 1'b0, 1, 0);
    issue("eq_t",   OP_EQ,  8'h5A, 8'h5A, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1, 0);
    issue("sub_z",  OP_SUB, 8'h05, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
    issue("add_v",  OP_ADD, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b0, 1'b1, 1, 0);
    issue("sub_v",  OP_SUB, 8'h80, 8'h01, 16'h007F, 1'b0, 1'b0, 1'b1, 1, 0);
    issue("gt_f",   OP_GT,  8'h03, 8'h09, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
    issue("shr7",   OP_SHR, 8'h81, 8'h0F, 16'h0001, 1'b0, 1'b0, 1'b0, 1, 0);
    issue("shl7",   OP_SHL, 8'hFF, 8'h07, 16'h7F80, 1'b0, 1'b0, 1'b0, 1, 0);
    issue("dflt",   4'b1001, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
    issue("mul_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 9, 8);
    issue("mul_dd", OP_MUL, 8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0, 1'b0, 9, 8);
    issue("mul_0",  OP_MUL, 8'h00, 8'h37, 16'h0000, 1'b1, 1'b0, 1'b0, 9, 8);

    // consumer stalls: result must hold and the block must refuse new work
    out_ready = 1'b0;
    issue("shl3",   OP_SHL, 8'h81, 8'h0B, 16'h0408, 1'b0, 1'b0, 1'b0, 1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", result, 16'h0408);
      chk("hold_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    b2b("b2b_add", OP_ADD, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0, 1'b0);
    b2b("b2b_and", OP_AND, 8'hC3, 8'h0F, 16'h0003, 1'b0, 1'b0, 1'b0);
    b2b("b2b_or",  OP_OR,  8'hC3, 8'h0F, 16'h00CF, 1'b0, 1'b0, 1'b0);
    b2b("b2b_xor", OP_XOR, 8'hC3, 8'h0F, 16'h00CC, 1'b0, 1'b0, 1'b0);
    b2b("b2b_gt",  OP_GT,  8'h09, 8'h03, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_tail_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;

    // reset in the middle of a multiply aborts it
    sel      = OP_MUL;
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", result, 16'h0000);
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_state", dbg_state, IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    @(posedge clk);
    #1;
    issue("post_rst", OP_ADD, 8'h12, 8'h34, 16'h0046, 1'b0, 1'b0, 1'b0, 1, 0);

`ifdef SEQ_ALU_DIV_EN
    issue("div_7",  OP_DIV, 8'd100, 8'd7,  16'h020E, 1'b0, 1'b0, 1'b0, 9, 8);
    issue("div_16", OP_DIV, 8'hFF,  8'h10, 16'h0F0F, 1'b0, 1'b0, 1'b0, 9, 8);
    issue("div_0",  OP_DIV, 8'd100, 8'd0,  16'h64FF, 1'b0, 1'b0, 1'b1, 9, 8);
`else
    issue("op0111", OP_DIV, 8'd100, 8'd7,  16'h0000, 1'b1, 1'b0, 1'b0, 1, 0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
